// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-subset CPU: fetch, decode, execute and retire one instruction per clock.
// Holds its own PC, instruction ROM, 32x32 register file, ALU and data RAM, with debug views of all state.
module single_cycle_cpu #(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "instr.mem"
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pcout,
  output logic [31:0] instrout,
  output logic [31:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
  output logic [31:0] t0,  t1,  t2,  t3,  t4,  t5,  t6,  t7,
  output logic [31:0] s0,  s1,  s2,  s3,  s4,  s5,  s6,  s7,
  output logic [31:0] t8,  t9,
  output logic [31:0] r26, r27, r28, r29, r30, r31,
  output logic        Zero,
  output logic [31:0] aluresult,
  output logic [31:0] readdata1,
  output logic [31:0] readdata2,
  output logic [31:0] writedata,
  output logic [4:0]  chooserd,
  output logic        RegWrite,
  output logic [31:0] d0, d1, d2,
  output logic        MemWrite
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOR, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  logic [31:0] imem [IMEM_DEPTH];

  // ROM words start at 0 and execute as nop until a program is placed in them.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
  end

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] dmem_q [DMEM_DEPTH];
  logic [31:0] dmem_d [DMEM_DEPTH];

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_ext, alu_b, pc_plus4, dmem_rdata;
  logic [DA-1:0] dmem_idx;

  logic    reg_write, reg_dst_rd, alu_src_imm, imm_zext, mem_write, mem_to_reg;
  logic    branch_eq, branch_ne, jump, link, branch_taken;
  alu_op_e alu_op;

  assign instr    = imem[pc_q[IA+1:2]];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_ext  = imm_zext ? {16'h0000, imm} : imm_sext;
  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: every signal assigned in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    reg_write   = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    link        = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      6'h00: begin
        reg_dst_rd = 1'b1;
        reg_write  = 1'b1;
        case (funct)
          6'h20:   alu_op = ALU_ADD;
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h2A:   alu_op = ALU_SLT;
          6'h27:   alu_op = ALU_NOR;
          6'h00:   alu_op = ALU_SLL;
          6'h02:   alu_op = ALU_SRL;
          default: reg_write = 1'b0;
        endcase
      end
      6'h08: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_ADD; end
      6'h0C: begin reg_write = 1'b1; alu_src_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
      6'h0D: begin reg_write = 1'b1; alu_src_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR; end
      6'h0A: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_SLT; end
      6'h0F: begin reg_write = 1'b1; alu_op = ALU_LUI; end
      6'h23: begin reg_write = 1'b1; alu_src_imm = 1'b1; mem_to_reg = 1'b1; end
      6'h2B: begin mem_write = 1'b1; alu_src_imm = 1'b1; end
      6'h04: begin branch_eq = 1'b1; alu_op = ALU_SUB; end
      6'h05: begin branch_ne = 1'b1; alu_op = ALU_SUB; end
      6'h02: jump = 1'b1;
      6'h03: begin jump = 1'b1; link = 1'b1; reg_write = 1'b1; end
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? imm_ext : readdata2;

  always_comb begin
    case (alu_op)
      ALU_ADD: aluresult = readdata1 + alu_b;
      ALU_SUB: aluresult = readdata1 - alu_b;
      ALU_AND: aluresult = readdata1 & alu_b;
      ALU_OR:  aluresult = readdata1 | alu_b;
      ALU_SLT: aluresult = {31'd0, $signed(readdata1) < $signed(alu_b)};
      ALU_NOR: aluresult = ~(readdata1 | alu_b);
      ALU_SLL: aluresult = alu_b << shamt;
      ALU_SRL: aluresult = alu_b >> shamt;
      ALU_LUI: aluresult = {imm, 16'h0000};
      default: aluresult = '0;
    endcase
  end

  assign Zero         = (aluresult == 32'd0);
  assign dmem_idx     = aluresult[DA+1:2];
  assign dmem_rdata   = dmem_q[dmem_idx];
  assign readdata1    = regs_q[rs];
  assign readdata2    = regs_q[rt];
  assign chooserd     = link ? 5'd31 : (reg_dst_rd ? rd : rt);
  assign writedata    = mem_to_reg ? dmem_rdata : (link ? pc_plus4 : aluresult);
  assign branch_taken = (branch_eq && Zero) || (branch_ne && !Zero);

  always_comb begin
    if (jump)              pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch_taken) pc_d = pc_plus4 + (imm_sext << 2);
    else                   pc_d = pc_plus4;
    pc_d = pc_d & PC_MASK;
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_write && chooserd != 5'd0) regs_d[chooserd] = writedata;
  end

  always_comb begin
    dmem_d = dmem_q;
    if (mem_write) dmem_d[dmem_idx] = readdata2;
  end

  // NOTE: the register file and data RAM are flop arrays cleared by reset, so they cannot map to block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      regs_q <= '{default: '0};
      dmem_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments let PC, registers and RAM all update from the same pre-edge values.
      pc_q   <= pc_d;
      regs_q <= regs_d;
      dmem_q <= dmem_d;
    end
  end

  assign pcout    = pc_q;
  assign instrout = instr;
  assign RegWrite = reg_write;
  assign MemWrite = mem_write;
  assign d0 = dmem_q[0];
  assign d1 = dmem_q[1];
  assign d2 = dmem_q[2];

  assign r0  = regs_q[0];   assign r1  = regs_q[1];   assign r2  = regs_q[2];   assign r3  = regs_q[3];
  assign r4  = regs_q[4];   assign r5  = regs_q[5];   assign r6  = regs_q[6];   assign r7  = regs_q[7];
  assign t0  = regs_q[8];   assign t1  = regs_q[9];   assign t2  = regs_q[10];  assign t3  = regs_q[11];
  assign t4  = regs_q[12];  assign t5  = regs_q[13];  assign t6  = regs_q[14];  assign t7  = regs_q[15];
  assign s0  = regs_q[16];  assign s1  = regs_q[17];  assign s2  = regs_q[18];  assign s3  = regs_q[19];
  assign s4  = regs_q[20];  assign s5  = regs_q[21];  assign s6  = regs_q[22];  assign s7  = regs_q[23];
  assign t8  = regs_q[24];  assign t9  = regs_q[25];  assign r26 = regs_q[26];  assign r27 = regs_q[27];
  assign r28 = regs_q[28];  assign r29 = regs_q[29];  assign r30 = regs_q[30];  assign r31 = regs_q[31];

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu: loads small programs into the ROM and checks each cycle's
// architectural state and datapath views against expectations queued in a scoreboard.
module tb_single_cycle_cpu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] pcout, instrout, aluresult, readdata1, readdata2, writedata, d0, d1, d2;
  logic [4:0]  chooserd;
  logic        Zero, RegWrite, MemWrite;
  logic [31:0] rv [32];

  single_cycle_cpu #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .IMEM_FILE("")) dut (
    .clk(clk), .rst(rst), .pcout(pcout), .instrout(instrout),
    .r0(rv[0]),   .r1(rv[1]),   .r2(rv[2]),   .r3(rv[3]),   .r4(rv[4]),   .r5(rv[5]),   .r6(rv[6]),   .r7(rv[7]),
    .t0(rv[8]),   .t1(rv[9]),   .t2(rv[10]),  .t3(rv[11]),  .t4(rv[12]),  .t5(rv[13]),  .t6(rv[14]),  .t7(rv[15]),
    .s0(rv[16]),  .s1(rv[17]),  .s2(rv[18]),  .s3(rv[19]),  .s4(rv[20]),  .s5(rv[21]),  .s6(rv[22]),  .s7(rv[23]),
    .t8(rv[24]),  .t9(rv[25]),  .r26(rv[26]), .r27(rv[27]), .r28(rv[28]), .r29(rv[29]), .r30(rv[30]), .r31(rv[31]),
    .Zero(Zero), .aluresult(aluresult), .readdata1(readdata1), .readdata2(readdata2),
    .writedata(writedata), .chooserd(chooserd), .RegWrite(RegWrite),
    .d0(d0), .d1(d1), .d2(d2), .MemWrite(MemWrite)
  );

  localparam int S_PC = 32, S_INSTR = 33, S_ZERO = 34, S_ALU = 35, S_WD = 36, S_RD = 37;
  localparam int S_RW = 38, S_MW = 39, S_D0 = 40, S_D1 = 41, S_D2 = 42, S_RD1 = 43, S_RD2 = 44;

  string       tag_q [$];
  int          sel_q [$];
  logic [31:0] val_q [$];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [31:0] observe(int sel);
    if (sel < 32) return rv[sel];
    case (sel)
      S_PC:    return pcout;
      S_INSTR: return instrout;
      S_ZERO:  return {31'd0, Zero};
      S_ALU:   return aluresult;
      S_WD:    return writedata;
      S_RD:    return {27'd0, chooserd};
      S_RW:    return {31'd0, RegWrite};
      S_MW:    return {31'd0, MemWrite};
      S_D0:    return d0;
      S_D1:    return d1;
      S_D2:    return d2;
      S_RD1:   return readdata1;
      S_RD2:   return readdata2;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sel, input logic [31:0] val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(val);
  endtask

  task automatic expect_reg(input int idx, input logic [31:0] val);
    expect_sig($sformatf("reg%0d", idx), idx, val);
  endtask

  task automatic cmp_all();
    while (sel_q.size() > 0) begin
      string       tag = tag_q.pop_front();
      int          sel = sel_q.pop_front();
      logic [31:0] exp = val_q.pop_front();
      logic [31:0] obs = observe(sel);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL %s: observed 0x%08h expected 0x%08h (pc 0x%08h)", tag, obs, exp, pcout);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_prog(input logic [31:0] words [$]);
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
    for (int i = 0; i < words.size(); i++) dut.imem[i] = words[i];
  endtask

  logic [31:0] prog_a [$];
  logic [31:0] prog_b [$];

  initial begin
    prog_a = '{32'h20080005, 32'h2009FFFD, 32'h01095020, 32'h01095822, 32'h01096024, 32'h01096825,
               32'h0109702A, 32'h01097827, 32'hAC080004, 32'h8C100004, 32'h11100001, 32'h20180063,
               32'h15100001, 32'h20110007, 32'h3C121234, 32'h00089900, 32'h0009A702, 32'h3515FFF0,
               32'h3136FF00, 32'h2937FFFF, 32'h20000009, 32'hAC0D0008, 32'hFC000000};
    prog_b = '{32'h20080001, 32'h0800000A, 32'h0, 32'h0, 32'h0C000014, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0, 32'h08000004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h20090002};
    #1;
    load_prog(prog_a);

    @(negedge clk);
    expect_sig("reset_pc", S_PC, 32'h0);
    expect_sig("reset_instr", S_INSTR, 32'h20080005);
    for (int i = 0; i < 32; i++) expect_reg(i, 32'h0);
    expect_sig("reset_d0", S_D0, 32'h0);
    expect_sig("reset_d1", S_D1, 32'h0);
    expect_sig("reset_d2", S_D2, 32'h0);
    cmp_all();
    rst = 1'b0;

    step();
    expect_sig("pc_after_first_edge", S_PC, 32'h4);
    expect_reg(8, 32'h5);
    expect_sig("addi_neg_alu", S_ALU, 32'hFFFFFFFD);
    expect_sig("addi_neg_rd", S_RD, 32'd9);
    expect_sig("addi_neg_rw", S_RW, 32'd1);
    cmp_all();
    step();
    expect_reg(9, 32'hFFFFFFFD);
    expect_sig("add_alu", S_ALU, 32'h2);
    expect_sig("add_wd", S_WD, 32'h2);
    expect_sig("add_rd", S_RD, 32'd10);
    cmp_all();
    step(); expect_reg(10, 32'h2); expect_sig("sub_alu", S_ALU, 32'h8); cmp_all();
    step(); expect_reg(11, 32'h8); expect_sig("and_alu", S_ALU, 32'h5); cmp_all();
    step(); expect_reg(12, 32'h5); expect_sig("or_alu", S_ALU, 32'hFFFFFFFD); cmp_all();
    step();
    expect_reg(13, 32'hFFFFFFFD);
    expect_sig("slt_alu", S_ALU, 32'h0);
    expect_sig("slt_zero", S_ZERO, 32'h1);
    cmp_all();
    step(); expect_reg(14, 32'h0); expect_sig("nor_alu", S_ALU, 32'h2); cmp_all();

    step();
    expect_reg(15, 32'h2);
    expect_sig("sw_pc", S_PC, 32'h20);
    expect_sig("sw_mw", S_MW, 32'd1);
    expect_sig("sw_rw", S_RW, 32'd0);
    expect_sig("sw_addr", S_ALU, 32'h4);
    expect_sig("sw_rd2", S_RD2, 32'h5);
    cmp_all();
    step();
    expect_sig("d1_after_sw", S_D1, 32'h5);
    expect_sig("lw_mw", S_MW, 32'd0);
    expect_sig("lw_rw", S_RW, 32'd1);
    expect_sig("lw_rd", S_RD, 32'd16);
    expect_sig("lw_wd", S_WD, 32'h5);
    cmp_all();

    step();
    expect_reg(16, 32'h5);
    expect_sig("beq_pc", S_PC, 32'h28);
    expect_sig("beq_zero", S_ZERO, 32'd1);
    expect_sig("beq_rw", S_RW, 32'd0);
    cmp_all();
    step();
    expect_sig("beq_target_pc", S_PC, 32'h30);
    expect_sig("bne_zero", S_ZERO, 32'd1);
    cmp_all();
    step(); expect_sig("bne_fallthrough_pc", S_PC, 32'h34); expect_reg(24, 32'h0); cmp_all();
    step(); expect_reg(17, 32'h7); expect_sig("lui_alu", S_ALU, 32'h12340000); cmp_all();
    step(); expect_reg(18, 32'h12340000); expect_sig("sll_alu", S_ALU, 32'h50); cmp_all();
    step(); expect_reg(19, 32'h50); expect_sig("srl_alu", S_ALU, 32'hF); cmp_all();
    step(); expect_reg(20, 32'hF); expect_sig("ori_alu", S_ALU, 32'hFFF5); cmp_all();
    step(); expect_reg(21, 32'hFFF5); expect_sig("andi_alu", S_ALU, 32'hFF00); cmp_all();
    step(); expect_reg(22, 32'hFF00); expect_sig("slti_alu", S_ALU, 32'h1); cmp_all();
    step();
    expect_reg(23, 32'h1);
    expect_sig("addi_r0_rd", S_RD, 32'd0);
    expect_sig("addi_r0_wd", S_WD, 32'h9);
    cmp_all();
    step();
    expect_reg(0, 32'h0);
    expect_sig("sw2_mw", S_MW, 32'd1);
    expect_sig("sw2_rd2", S_RD2, 32'hFFFFFFFD);
    cmp_all();
    step();
    expect_sig("d2_after_sw", S_D2, 32'hFFFFFFFD);
    expect_sig("nop_pc", S_PC, 32'h58);
    expect_sig("nop_rw", S_RW, 32'd0);
    expect_sig("nop_mw", S_MW, 32'd0);
    cmp_all();
    step(); expect_sig("nop_next_pc", S_PC, 32'h5C); cmp_all();

    rst = 1'b1;
    #1;
    load_prog(prog_b);
    #1;
    expect_sig("rst2_pc", S_PC, 32'h0);
    expect_reg(8, 32'h0);
    expect_sig("rst2_d1", S_D1, 32'h0);
    expect_sig("rst2_instr", S_INSTR, 32'h20080001);
    cmp_all();
    @(negedge clk);
    rst = 1'b0;
    step(); expect_sig("j_pc", S_PC, 32'h4); expect_reg(8, 32'h1); cmp_all();
    step(); expect_sig("j10_pc", S_PC, 32'h28); cmp_all();
    step();
    expect_sig("jal_pc", S_PC, 32'h10);
    expect_sig("jal_rw", S_RW, 32'd1);
    expect_sig("jal_rd", S_RD, 32'd31);
    expect_sig("jal_wd", S_WD, 32'h14);
    cmp_all();
    step(); expect_sig("jal_target_pc", S_PC, 32'h50); expect_reg(31, 32'h14); cmp_all();
    step(); expect_sig("after_jal_pc", S_PC, 32'h54); expect_reg(9, 32'h2); cmp_all();

    #2 rst = 1'b1;
    #1;
    expect_sig("async_rst_pc", S_PC, 32'h0);
    expect_reg(8, 32'h0);
    expect_reg(9, 32'h0);
    expect_reg(31, 32'h0);
    cmp_all();
    @(negedge clk);
    expect_sig("held_rst_pc", S_PC, 32'h0);
    cmp_all();
    rst = 1'b0;
    step(); expect_sig("rerun_pc", S_PC, 32'h4); expect_reg(8, 32'h1); cmp_all();
    step(); expect_sig("rerun_j_pc", S_PC, 32'h28); cmp_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
